// File: rtl/muldiv_ctrl_if.sv
// Bundle between the EX/MEM1 pipeline control and the HI/LO multiply/divide sequencer.
//   master: pipeline side. It drives the operation, operands, advance enables and flush,
//           and observes the busy/stall requests and HI/LO.
//   slave : sequencer side (muldiv_ctrl).
interface muldiv_ctrl_if;
  logic [2:0]  EX_MDOp;      // 0 none,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO
  logic        EX_valid;     // EX holds a real instruction
  logic [31:0] EX_A;         // rs operand (bypassed)
  logic [31:0] EX_B;         // rt operand (bypassed)
  logic        EX_MEM1Wr;    // EX->MEM1 advance
  logic        MEM1_MEM2Wr;  // MEM1->MEM2 advance
  logic        MEM1_ee;      // flush at MEM1
  logic        isbusy;       // divide in flight
  logic        MUL_sign;     // multiply in flight, freezes pipeline
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output EX_MDOp, EX_valid, EX_A, EX_B, EX_MEM1Wr, MEM1_MEM2Wr, MEM1_ee,
    input  isbusy, MUL_sign, HI, LO
  );

  modport slave (
    input  EX_MDOp, EX_valid, EX_A, EX_B, EX_MEM1Wr, MEM1_MEM2Wr, MEM1_ee,
    output isbusy, MUL_sign, HI, LO
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer.
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from EX. It runs a MUL_LAT-deep multiply pipe and a
// 32-iteration restoring divide, and owns HI/LO. The issuing instruction is tracked through
// EX/MEM1 so that a MEM1 flush cancels the operation before it commits.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - muldiv_ctrl_if.slave (op/operands/advance/flush in; isbusy/MUL_sign/HI/LO out)
// Parameter MUL_LAT (>=1): multiply latency in cycles.
// Optional macro MULDIV_EARLY_EXIT_EN: a divide whose nonzero divisor magnitude exceeds the
// dividend magnitude goes straight to the sign-fix cycle.
module muldiv_ctrl #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic           clk,
  input logic           rst,
  muldiv_ctrl_if.slave  bus
);

  localparam int unsigned CntW = (MUL_LAT > 32) ? $clog2(MUL_LAT) : 5;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e            state_q, state_d;
  logic [1:0]        pos_q, pos_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic              sq_q, sq_d, sr_q, sr_d, dz_q, dz_d;
  logic [63:0]       mul_pipe_q [MUL_LAT];

  logic        mul_op, div_op, op_signed, start, abort;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [63:0] a_ext, b_ext;
  logic [32:0] shifted, diff;

  assign mul_op    = (bus.EX_MDOp == 3'd1) | (bus.EX_MDOp == 3'd2);
  assign div_op    = (bus.EX_MDOp == 3'd3) | (bus.EX_MDOp == 3'd4);
  assign op_signed = (bus.EX_MDOp == 3'd1) | (bus.EX_MDOp == 3'd3);

  assign start = bus.EX_valid & (bus.EX_MDOp != 3'd0) & (state_q == StIdle) & ~bus.MEM1_ee;
  // The instruction has not yet passed MEM1, so a flush there kills the operation.
  assign abort = (state_q != StIdle) & bus.MEM1_ee & (pos_q != 2'd2);

  assign a_neg = op_signed & bus.EX_A[31];
  assign b_neg = op_signed & bus.EX_B[31];
  assign a_mag = a_neg ? -bus.EX_A : bus.EX_A;
  assign b_mag = b_neg ? -bus.EX_B : bus.EX_B;

  // The low 64 bits of the 33x33 signed product equal the 64-bit wrap product of the
  // extended operands.
  assign a_ext = {{32{a_neg}}, bus.EX_A};
  assign b_ext = {{32{b_neg}}, bus.EX_B};

  // One restoring step. rem < dvs is invariant, so bit 32 of diff is the borrow.
  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dz_d    = dz_q;

    if (pos_q == 2'd0 && bus.EX_MEM1Wr) begin
      pos_d = 2'd1;
    end else if (pos_q == 2'd1 && bus.MEM1_MEM2Wr) begin
      pos_d = 2'd2;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          pos_d = 2'd0;
          if (mul_op) begin
            state_d = StMul;
            cnt_d   = CntW'(MUL_LAT - 1);
          end else if (div_op) begin
            state_d = StDiv;
            cnt_d   = CntW'(31);
            dz_d    = (bus.EX_B == 32'd0);
            // On divide by zero rem holds |A| untouched so the fix cycle restores A.
            rem_d   = (bus.EX_B == 32'd0) ? a_mag : 32'd0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            sq_d    = a_neg ^ b_neg;
            sr_d    = a_neg;
`ifdef MULDIV_EARLY_EXIT_EN
            if (b_mag != 32'd0 && (b_mag > a_mag || a_mag == 32'd0)) begin
              state_d = StFix;
              quo_d   = 32'd0;
              rem_d   = a_mag;
            end
`endif
          end else if (bus.EX_MDOp == 3'd5) begin
            hi_d = bus.EX_A;
          end else if (bus.EX_MDOp == 3'd6) begin
            lo_d = bus.EX_A;
          end
        end
      end
      StMul: begin
        if (cnt_q == '0) begin
          hi_d    = mul_pipe_q[MUL_LAT-1][63:32];
          lo_d    = mul_pipe_q[MUL_LAT-1][31:0];
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDiv: begin
        if (!dz_q) begin
          if (!diff[32]) begin
            rem_d = diff[31:0];
            quo_d = {quo_q[30:0], 1'b1};
          end else begin
            rem_d = shifted[31:0];
            quo_d = {quo_q[30:0], 1'b0};
          end
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StFix: begin
        lo_d    = dz_q ? 32'hFFFF_FFFF : (sq_q ? -quo_q : quo_q);
        hi_d    = sr_q ? -rem_q : rem_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pos_q   <= 2'd2;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dz_q    <= dz_d;
    end
  end

  // Stage 0 captures the product at the start edge; the last stage is read when cnt hits 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) begin
        mul_pipe_q[i] <= '0;
      end
    end else begin
      if (start & mul_op) begin
        mul_pipe_q[0] <= a_ext * b_ext;
      end
      for (int i = 1; i < MUL_LAT; i++) begin
        mul_pipe_q[i] <= mul_pipe_q[i-1];
      end
    end
  end

  assign bus.isbusy   = (start & div_op) | (state_q == StDiv) | (state_q == StFix);
  assign bus.MUL_sign = (start & mul_op) | (state_q == StMul);
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. An operation-level timeline model predicts
// isbusy/MUL_sign/HI/LO every cycle. Directed cases pin the model with literal values, and
// randomized traffic with flushes and resets follows them.
module tb_muldiv_ctrl;
  localparam int unsigned MUL_LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_ctrl_if mif();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 1'b0;

  // Model: one pending operation, committing in relative cycle m_end after its start.
  int          m_kind = 0;   // 0 none, 1 multiply, 2 divide
  int          m_rel, m_end;
  int          m_pos  = 2;
  logic [31:0] m_hi = '0, m_lo = '0, m_rhi, m_rlo;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit start_now();
    return mif.EX_valid && (mif.EX_MDOp != 3'd0) && (m_kind == 0) && !mif.MEM1_ee;
  endfunction

  // Truncating division with MIPS-style sign rules and the divide-by-zero convention.
  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b,
                                          input bit sgn);
    logic [31:0] ua, ub, q, r;
    bit sa, sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    sa = sgn & a[31];
    sb = sgn & b[31];
    ua = sa ? -a : a;
    ub = sb ? -b : b;
    q  = ua / ub;
    r  = ua % ub;
    if (sa ^ sb) q = -q;
    if (sa) r = -r;
    return {r, q};
  endfunction

  function automatic bit early_ref(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    logic [31:0] ua, ub;
    ua = (sgn && a[31]) ? -a : a;
    ub = (sgn && b[31]) ? -b : b;
    return (ub != 0) && (ub > ua || ua == 0);
  endfunction

  always @(posedge clk) begin
    bit          st;
    int          old_pos;
    logic [63:0] p;
    st = start_now();
    if (rst) begin
      m_kind = 0;
      m_pos  = 2;
      m_hi   = '0;
      m_lo   = '0;
    end else begin
      old_pos = m_pos;
      if (m_pos == 0 && mif.EX_MEM1Wr) m_pos = 1;
      else if (m_pos == 1 && mif.MEM1_MEM2Wr) m_pos = 2;
      if (m_kind != 0) begin
        if (mif.MEM1_ee && old_pos < 2) begin
          m_kind = 0;
        end else if (m_rel == m_end) begin
          m_hi   = m_rhi;
          m_lo   = m_rlo;
          m_kind = 0;
        end else begin
          m_rel++;
        end
      end else if (st) begin
        m_pos = 0;
        m_rel = 1;
        case (mif.EX_MDOp)
          3'd1: begin
            p = longint'($signed(mif.EX_A)) * longint'($signed(mif.EX_B));
            {m_rhi, m_rlo} = p;
            m_kind = 1;
            m_end  = MUL_LAT;
          end
          3'd2: begin
            p = {32'd0, mif.EX_A} * {32'd0, mif.EX_B};
            {m_rhi, m_rlo} = p;
            m_kind = 1;
            m_end  = MUL_LAT;
          end
          3'd3, 3'd4: begin
            {m_rhi, m_rlo} = div_ref(mif.EX_A, mif.EX_B, mif.EX_MDOp == 3'd3);
            m_kind = 2;
            m_end  = 33;
`ifdef MULDIV_EARLY_EXIT_EN
            if (early_ref(mif.EX_A, mif.EX_B, mif.EX_MDOp == 3'd3)) m_end = 1;
`endif
          end
          3'd5: m_hi = mif.EX_A;
          3'd6: m_lo = mif.EX_A;
          default: ;
        endcase
      end
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    bit st, eb, em;
    if (cmp_on && !rst) begin
      st = start_now();
      eb = (st && (mif.EX_MDOp == 3'd3 || mif.EX_MDOp == 3'd4)) || (m_kind == 2);
      em = (st && (mif.EX_MDOp == 3'd1 || mif.EX_MDOp == 3'd2)) || (m_kind == 1);
      chk("isbusy", {31'd0, mif.isbusy}, {31'd0, eb});
      chk("MUL_sign", {31'd0, mif.MUL_sign}, {31'd0, em});
      chk("HI", mif.HI, m_hi);
      chk("LO", mif.LO, m_lo);
      if (mif.EX_valid && mif.EX_MDOp != 3'd0 && m_kind != 0) begin
        failures++;
        $display("FAIL protocol: op %0d issued while busy at %0t", mif.EX_MDOp, $time);
      end
    end
  end

  task automatic drive_idle();
    mif.EX_valid    = 1'b0;
    mif.EX_MDOp     = 3'd0;
    mif.EX_A        = '0;
    mif.EX_B        = '0;
    mif.EX_MEM1Wr   = 1'b1;
    mif.MEM1_MEM2Wr = 1'b1;
    mif.MEM1_ee     = 1'b0;
  endtask

  // Issue one op and count the cycles with isbusy|MUL_sign high (start cycle included).
  // Returns at the negedge of the first cycle where the results are visible.
  task automatic run_count(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit wr, input int ee_at, output int n);
    bit done;
    int k;
    @(posedge clk); #1;
    mif.EX_valid = 1'b1; mif.EX_MDOp = op; mif.EX_A = a; mif.EX_B = b;
    mif.EX_MEM1Wr = wr; mif.MEM1_MEM2Wr = wr; mif.MEM1_ee = 1'b0;
    n = 0; k = 0; done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!(mif.isbusy || mif.MUL_sign)) begin
        done = 1'b1;
        break;
      end
      n++;
      @(posedge clk); #1;
      mif.EX_valid = 1'b0; mif.EX_MDOp = 3'd0;
      k++;
      mif.MEM1_ee = (k == ee_at);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL timeout: busy never dropped for op %0d", op);
    end
    if (n == 0) begin
      @(posedge clk); #1;
      mif.EX_valid = 1'b0; mif.EX_MDOp = 3'd0;
      @(negedge clk);
    end
    mif.MEM1_ee = 1'b0;
  endtask

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  int n;
  int exp_n;

  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_HI", mif.HI, 32'd0);
    chk("reset_LO", mif.LO, 32'd0);
    chk("reset_isbusy", {31'd0, mif.isbusy}, 32'd0);
    chk("reset_MUL_sign", {31'd0, mif.MUL_sign}, 32'd0);
    cmp_on = 1'b1;

    run_count(3'd3, -32'sd7, 32'd2, 1'b1, -1, n);
    chk("div_n", n, 34);
    chk("div_LO", mif.LO, 32'hFFFF_FFFD);
    chk("div_HI", mif.HI, 32'hFFFF_FFFF);

    run_count(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, -1, n);
    chk("multu_n", n, MUL_LAT + 1);
    chk("multu_HI", mif.HI, 32'd1);
    chk("multu_LO", mif.LO, 32'hFFFF_FFFE);

    run_count(3'd4, 32'd100, 32'd0, 1'b1, -1, n);
    chk("divz_n", n, 34);
    chk("divz_LO", mif.LO, 32'hFFFF_FFFF);
    chk("divz_HI", mif.HI, 32'd100);

    // Flush at T+5 with the instruction still in EX: abort, HI/LO unchanged.
    run_count(3'd3, 32'd50, 32'd3, 1'b0, 5, n);
    chk("abort_n", n, 6);
    chk("abort_HI", mif.HI, 32'd100);
    chk("abort_LO", mif.LO, 32'hFFFF_FFFF);

    // Flush at T+10 after the instruction left MEM1: divide completes.
    run_count(3'd3, 32'd1000, 32'd7, 1'b1, 10, n);
    chk("late_ee_n", n, 34);
    chk("late_ee_LO", mif.LO, 32'd142);
    chk("late_ee_HI", mif.HI, 32'd6);

`ifdef MULDIV_EARLY_EXIT_EN
    exp_n = 2;
`else
    exp_n = 34;
`endif
    run_count(3'd4, 32'd3, 32'd10, 1'b1, -1, n);
    chk("small_div_n", n, exp_n);
    chk("small_div_LO", mif.LO, 32'd0);
    chk("small_div_HI", mif.HI, 32'd3);

    run_count(3'd6, 32'h1234, 32'd0, 1'b1, -1, n);
    chk("mtlo_n", n, 0);
    chk("mtlo_LO", mif.LO, 32'h1234);
    run_count(3'd5, 32'hCAFE, 32'd0, 1'b1, -1, n);
    chk("mthi_HI", mif.HI, 32'hCAFE);

    // Reset in the middle of a divide.
    @(posedge clk); #1;
    mif.EX_valid = 1'b1; mif.EX_MDOp = 3'd3; mif.EX_A = 32'd77; mif.EX_B = 32'd5;
    @(posedge clk); #1;
    mif.EX_valid = 1'b0; mif.EX_MDOp = 3'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_HI", mif.HI, 32'd0);
    chk("midrst_LO", mif.LO, 32'd0);
    chk("midrst_isbusy", {31'd0, mif.isbusy}, 32'd0);

    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      rst             = ($urandom_range(0, 399) == 0);
      mif.EX_MEM1Wr   = 1'($urandom_range(0, 1));
      mif.MEM1_MEM2Wr = 1'($urandom_range(0, 1));
      mif.MEM1_ee     = ($urandom_range(0, 19) == 0);
      mif.EX_A        = rand_opnd();
      mif.EX_B        = rand_opnd();
      if (m_kind == 0 && $urandom_range(0, 2) == 0) begin
        mif.EX_valid = 1'b1;
        mif.EX_MDOp  = 3'($urandom_range(1, 6));
      end else begin
        mif.EX_valid = 1'($urandom_range(0, 1));
        mif.EX_MDOp  = mif.EX_valid ? 3'd0 : 3'($urandom_range(0, 7));
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive_idle();
    repeat (40) @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencer for the HI/LO multiply/divide unit. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the EX stage, runs a pipelined multiply and a 32-iteration radix-2 divide, and owns the HI/LO registers. It generates `isbusy` and `MUL_sign` for the stall unit. It tracks the issuing instruction through EX and MEM1, so an operation whose instruction is flushed by `MEM1_ee` never commits to HI/LO.

## Interface
- `MUL_LAT`, default 2: multiply latency in cycles (≥1); the whole pipeline is frozen for this many cycles.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `EX_MDOp` in 3: 000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO.
- `EX_valid` in 1: EX holds a valid, non-bubble instruction.
- `EX_A` in 32: rs operand, already bypassed.
- `EX_B` in 32: rt operand, already bypassed.
- `EX_MEM1Wr` in 1: EX→MEM1 advance enable, from the stall unit.
- `MEM1_MEM2Wr` in 1: MEM1→MEM2 advance enable.
- `MEM1_ee` in 1: exception/interrupt flush at MEM1.
- `isbusy` out 1: divide in flight (or starting this cycle).
- `MUL_sign` out 1: multiply in flight; requests a whole-pipeline stall.
- `HI` out 32: HI register.
- `LO` out 32: LO register.

## Operation
- **States:** IDLE, MUL, DIV, FIX.
- **start** = `EX_valid` & (`EX_MDOp` != 0) & (state == IDLE) & ~`MEM1_ee`.
- **Instruction position counter `pos`:**
  - Loaded to 0 on start.
  - 0→1 when `EX_MEM1Wr`; 1→2 when `MEM1_MEM2Wr`; saturates at 2.
  - A `MEM1_ee` while `pos` ≤ 1 aborts: state goes to IDLE and HI/LO are not written.
- **MTHI / MTLO:** write `EX_A` to HI/LO at the edge ending the start cycle; state stays IDLE.
- **MULT / MULTU:**
  - IDLE→MUL. Operands are latched and sign- or zero-extended to 33 bits; the product is taken from a `MUL_LAT`-deep register pipe.
  - Counter runs from `MUL_LAT`-1 to 0. At 0, HI = product[63:32], LO = product[31:0], then →IDLE.
- **DIV / DIVU:**
  - IDLE→DIV. Latch |A| and |B| (raw values for DIVU), plus the quotient sign (sa^sb) and remainder sign (sa).
  - 32 restoring iterations, one per cycle, counter 31→0. At 0 →FIX.
  - FIX applies the sign correction: quotient negated if sa^sb, remainder negated if sa. Writes LO = quotient, HI = remainder, then →IDLE.
- **Divide by zero:** LO = 32'hFFFF_FFFF, HI = dividend (`EX_A`). The full iteration count still runs.
- **Outputs:**
  - `isbusy` = start&div_op | state ∈ {DIV, FIX}.
  - `MUL_sign` = start&mul_op | state == MUL.
- **Protocol violation:** a nonzero `EX_MDOp` with `EX_valid` while not IDLE is ignored. It cannot occur because `RHL_visit` stalls ID, and the bench asserts it never happens.
- **Reset:** state IDLE, `pos` = 2, counters 0, HI = LO = 0, `isbusy` = `MUL_sign` = 0.

## Timing
- Start cycle T: `isbusy` or `MUL_sign` is combinationally high in T.
- **MUL:** `MUL_sign` high for T..T+`MUL_LAT`. HI/LO are valid at T+`MUL_LAT`+1. The pipeline is frozen, so `pos` stays 0 and any `MEM1_ee` in that window aborts.
- **DIV:** `isbusy` high for T..T+33 (32 DIV cycles plus FIX at T+33). HI/LO are valid at T+34. The pipeline keeps running.
- **MTHI/MTLO:** HI/LO are valid at T+1 with no busy signal.
- **`MEM1_ee` in cycle T:** no start.
- **`MEM1_ee` in the final DIV/FIX/MUL cycle with `pos` ≤ 1:** the abort wins over the write.
- **`rst` mid-operation:** immediately returns to the reset state and clears HI/LO.

## Configuration
- `MULDIV_EARLY_EXIT_EN` defined: when the DIV/DIVU divisor magnitude exceeds the dividend magnitude (or the dividend is 0) and the divisor is nonzero, go IDLE→FIX directly. Quotient = 0, remainder = dividend, and `isbusy` is high only for T and T+1.
- Undefined: every divide takes the full 34-cycle schedule.

## Test plan
- DIV with A=-7, B=2 → `isbusy` high 34 cycles; LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF at T+34.
- MULTU with A=32'hFFFF_FFFF, B=2, `MUL_LAT`=2 → `MUL_sign` high T..T+2; HI=1, LO=32'hFFFF_FFFE.
- DIVU with A=100, B=0 → LO=32'hFFFF_FFFF, HI=100 after 34 cycles.
- DIV started, `EX_MEM1Wr` held 0, `MEM1_ee` at T+5 → state IDLE at T+6; HI/LO keep prior values.
- DIV started, advanced to `pos`=2, `MEM1_ee` at T+10 → divide completes; HI/LO are written at T+34.
- With `MULDIV_EARLY_EXIT_EN`: DIVU A=3, B=10 → `isbusy` high 2 cycles; LO=0, HI=3. Then MTLO 32'h1234 → LO=32'h1234 next cycle.
